// File: rtl/alu_dr_pkg.sv
// Shared dual-rail codes, FSM state type and single-pair encode/decode helpers
// for the clocked initiator of the dual-rail ALU.
package alu_dr_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, NULLP, RESP} state_e;

  function automatic logic [1:0] dr_encode(input logic bin);
    return bin ? DR_ONE : DR_ZERO;
  endfunction

  // Only the logic-1 code decodes to 1; NULL and the illegal code both read as 0.
  function automatic logic dr_decode(input logic [1:0] pair);
    return pair == DR_ONE;
  endfunction

endpackage

// File: rtl/alu_dr_bridge_if.sv
// Request, response and dual-rail ALU signals of the bridge. The slave modport
// is the bridge; the master modport is the synchronous client plus the ALU.
interface alu_dr_bridge_if #(parameter int WIDTH = 4);

  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds valid and payload stable until that edge.
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               req_op;

  logic [2*WIDTH-1:0] dr_a;
  logic [2*WIDTH-1:0] dr_b;
  logic [1:0]         dr_opr;
  logic [2*WIDTH-1:0] dr_sum;
  logic [1:0]         dr_of;
  logic [1:0]         dr_neg;
  logic [1:0]         dr_zero;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_sum;
  logic               rsp_of;
  logic               rsp_neg;
  logic               rsp_zero;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    input  dr_sum, dr_of, dr_neg, dr_zero,
    output req_ready, dr_a, dr_b, dr_opr,
    output rsp_valid, rsp_sum, rsp_of, rsp_neg, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    output dr_sum, dr_of, dr_neg, dr_zero,
    input  req_ready, dr_a, dr_b, dr_opr,
    input  rsp_valid, rsp_sum, rsp_of, rsp_neg, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_dr_bridge_detect.sv
// Completion / null / illegal detection and binary decode over a synchronized
// dual-rail bus of PAIRS pairs.
module dr_detect
  import alu_dr_pkg::*;
#(
  parameter int PAIRS = 7
) (
  input  logic [2*PAIRS-1:0] rails,
  output logic               complete,
  output logic               all_null,
  output logic               illegal,
  output logic [PAIRS-1:0]   data
);

  logic [1:0] pair;

  always_comb begin
    complete = 1'b1;
    all_null = 1'b1;
    illegal  = 1'b0;
    data     = '0;
    pair     = DR_NULL;
    for (int i = 0; i < PAIRS; i++) begin
      pair = rails[2*i +: 2];
      if (pair == DR_NULL) complete = 1'b0;
      else                 all_null = 1'b0;
      if (pair == DR_ILL)  illegal  = 1'b1;
      data[i] = dr_decode(pair);
    end
  end

endmodule

// File: rtl/alu_dr_bridge.sv
// Clocked four-phase initiator for the dual-rail ALU: encodes a binary request,
// waits for DATA then NULL on the synchronized result, returns the decoded result.
module alu_dr_bridge
  import alu_dr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_dr_bridge_if.slave   bus,
  output state_e           dbg_state
);

  localparam int PAIRS = WIDTH + 3;
  localparam int SW    = 2 * PAIRS;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e             state;
  logic [CW-1:0]      count;
  logic [SW-1:0]      sync1, sync2;
  logic               complete, all_null, illegal;
  logic [PAIRS-1:0]   dec;
  logic [2*WIDTH-1:0] dr_a_q, dr_b_q;
  logic [1:0]         dr_opr_q;
  logic               rsp_valid_q, err_q;
  logic [WIDTH-1:0]   sum_q;
  logic               of_q, neg_q, zero_q;

  function automatic logic [2*WIDTH-1:0] enc_bus(input logic [WIDTH-1:0] bin);
    logic [2*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[2*i +: 2] = dr_encode(bin[i]);
    return v;
  endfunction

  // Rails are monotonic within a phase, so each rail is synchronized on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.dr_zero, bus.dr_neg, bus.dr_of, bus.dr_sum};
      sync2 <= sync1;
    end
  end

  dr_detect #(.PAIRS(PAIRS)) u_detect (
    .rails    (sync2),
    .complete (complete),
    .all_null (all_null),
    .illegal  (illegal),
    .data     (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dr_a_q      <= '0;
      dr_b_q      <= '0;
      dr_opr_q    <= DR_NULL;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sum_q       <= '0;
      of_q        <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && all_null) begin
            dr_a_q   <= enc_bus(bus.req_a);
            dr_b_q   <= enc_bus(bus.req_b);
            dr_opr_q <= dr_encode(bus.req_op);
            count    <= '0;
            err_q    <= 1'b0;
            sum_q    <= '0;
            of_q     <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (illegal) err_q <= 1'b1;
          if (complete) begin
            sum_q    <= dec[WIDTH-1:0];
            of_q     <= dec[WIDTH];
            neg_q    <= dec[WIDTH+1];
            zero_q   <= dec[WIDTH+2];
            dr_a_q   <= '0;
            dr_b_q   <= '0;
            dr_opr_q <= DR_NULL;
            count    <= '0;
            state    <= NULLP;
          end else if (count == CNT_MAX) begin
            err_q    <= 1'b1;
            dr_a_q   <= '0;
            dr_b_q   <= '0;
            dr_opr_q <= DR_NULL;
            count    <= '0;
            state    <= NULLP;
          end else begin
            count <= count + 1'b1;
          end
        end
        NULLP: begin
          if (illegal) err_q <= 1'b1;
          if (all_null) begin
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (count == CNT_MAX) begin
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && all_null;
  assign bus.dr_a      = dr_a_q;
  assign bus.dr_b      = dr_b_q;
  assign bus.dr_opr    = dr_opr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_of    = of_q;
  assign bus.rsp_neg   = neg_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_dr_bridge.sv
// Bench for alu_dr_bridge: a behavioural dual-rail ALU with programmable delays,
// a scoreboard of expected responses and directed scenarios with literal checks.
module tb_alu_dr_bridge;
  import alu_dr_pkg::*;

  localparam int WIDTH = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  alu_dr_bridge_if #(.WIDTH(WIDTH)) bus ();

  alu_dr_bridge #(.WIDTH(WIDTH), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  // {check_data, err, of, neg, zero, sum[3:0]}
  logic [8:0] exp_q[$];

  int data_delay = 3;
  int null_delay = 1;
  bit never_data = 1'b0;
  bit ill_mode = 1'b0;
  bit out_data = 1'b0;
  int mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference ALU: {of, neg, zero, sum}; op 0 adds, op 1 subtracts, flags are two's complement.
  function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic op);
    int sa, sb, sr;
    logic [3:0] r;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    sr = op ? sa - sb : sa + sb;
    r  = 4'(sr);
    return {(sr < -8 || sr > 7), r[3], (r == 4'd0), r};
  endfunction

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return e;
  endfunction

  // Behavioural asynchronous ALU, updated on the falling edge.
  logic [6:0] m_res;
  logic [3:0] m_a, m_b;
  logic       m_in_data, m_in_null;

  always @(negedge clk) begin
    m_in_data = 1'b1;
    m_in_null = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.dr_a[2*i +: 2] == 2'b00 || bus.dr_b[2*i +: 2] == 2'b00) m_in_data = 1'b0;
      if (bus.dr_a[2*i +: 2] != 2'b00 || bus.dr_b[2*i +: 2] != 2'b00) m_in_null = 1'b0;
      m_a[i] = bus.dr_a[2*i+1];
      m_b[i] = bus.dr_b[2*i+1];
    end
    if (bus.dr_opr == 2'b00) m_in_data = 1'b0;
    else                     m_in_null = 1'b0;

    if (!out_data && m_in_data && !never_data) begin
      mcnt++;
      if (mcnt >= data_delay) begin
        m_res    = alu_ref(m_a, m_b, bus.dr_opr[1]);
        out_data = 1'b1;
        mcnt     = 0;
      end
    end else if (out_data && m_in_null) begin
      mcnt++;
      if (mcnt >= null_delay) begin
        out_data = 1'b0;
        mcnt     = 0;
      end
    end else begin
      mcnt = 0;
    end

    if (out_data) begin
      bus.dr_sum = enc4(m_res[3:0]);
      if (ill_mode) bus.dr_sum[1:0] = 2'b11;
      bus.dr_of   = m_res[6] ? 2'b10 : 2'b01;
      bus.dr_neg  = m_res[5] ? 2'b10 : 2'b01;
      bus.dr_zero = m_res[4] ? 2'b10 : 2'b01;
    end else begin
      bus.dr_sum  = '0;
      bus.dr_of   = 2'b00;
      bus.dr_neg  = 2'b00;
      bus.dr_zero = 2'b00;
    end
  end

  // Response checker: stability under backpressure and in-order scoreboard match.
  bit         hold = 1'b0;
  logic [7:0] held;
  logic [8:0] e_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_hold_data",
              32'({bus.rsp_err, bus.rsp_of, bus.rsp_neg, bus.rsp_zero, bus.rsp_sum}), 32'(held));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        hold = 1'b0;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got response sum=0x%0h err=%0b, expected none",
                   bus.rsp_sum, bus.rsp_err);
        end else begin
          e_pop = exp_q.pop_front();
          if (bus.rsp_err !== e_pop[7]) begin
            miscompares++;
            $display("FAIL rsp_err: got %0b, expected %0b", bus.rsp_err, e_pop[7]);
          end
          if (e_pop[8])
            check("rsp_data", 32'({bus.rsp_of, bus.rsp_neg, bus.rsp_zero, bus.rsp_sum}),
                  32'(e_pop[6:0]));
        end
      end else if (bus.rsp_valid) begin
        hold = 1'b1;
        held = {bus.rsp_err, bus.rsp_of, bus.rsp_neg, bus.rsp_zero, bus.rsp_sum};
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic op, input bit keep);
    logic [6:0] r;
    int n;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 600) begin
      step();
      n++;
    end
    check("req_accept", 32'(bus.req_ready), 32'd1);
    r = alu_ref(a, b, op);
    if (ill_mode) r[0] = 1'b0;
    if (bus.req_ready) exp_q.push_back({~never_data, never_data | ill_mode, r});
    step();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 600) begin
      step();
      n++;
    end
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();

    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_dr_a", 32'(bus.dr_a), 32'd0);
    check("reset_dr_b", 32'(bus.dr_b), 32'd0);
    check("reset_dr_opr", 32'(bus.dr_opr), 32'd0);
    check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_of, bus.rsp_neg,
                            bus.rsp_zero, bus.rsp_sum}), 32'd0);
    rst_n = 1'b1;
    step();

    // Sum path: 3 + 2 with a 3-cycle ALU.
    data_delay = 3;
    null_delay = 1;
    send(4'd3, 4'd2, 1'b0, 1'b0);
    check("t1_dr_a", 32'(bus.dr_a), 32'h5A);
    check("t1_dr_b", 32'(bus.dr_b), 32'h59);
    check("t1_dr_opr", 32'(bus.dr_opr), 32'd1);
    wait_rsp("t1");
    check("t1_sum", 32'(bus.rsp_sum), 32'd5);
    check("t1_flags", 32'({bus.rsp_of, bus.rsp_neg, bus.rsp_zero, bus.rsp_err}), 32'd0);
    drain("t1", 50);

    // Backpressure: 7 - 1 held for 5 cycles while a second request waits.
    bus.rsp_ready = 1'b0;
    send(4'd7, 4'd1, 1'b1, 1'b0);
    wait_rsp("t2");
    check("t2_sum", 32'(bus.rsp_sum), 32'd6);
    bus.req_a     = 4'd4;
    bus.req_b     = 4'd4;
    bus.req_op    = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_ready_low", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    send(4'd4, 4'd4, 1'b0, 1'b0);
    wait_rsp("t2b");
    check("t2b_sum", 32'(bus.rsp_sum), 32'd8);
    check("t2b_of_neg_zero", 32'({bus.rsp_of, bus.rsp_neg, bus.rsp_zero}), 32'b110);
    drain("t2", 50);

    // Timeout: the ALU never produces data.
    never_data = 1'b1;
    send(4'd1, 4'd1, 1'b0, 1'b0);
    n = 0;
    while (bus.dr_a != 8'd0 && n < 400) begin
      step();
      n++;
    end
    check("t3_timeout_window", 32'(n >= 255 && n <= 257), 32'd1);
    wait_rsp("t3");
    check("t3_err", 32'(bus.rsp_err), 32'd1);
    drain("t3", 50);
    never_data = 1'b0;

    // Illegal code on sum bit 0: 1 + 0 decodes to sum 0 with err.
    ill_mode = 1'b1;
    send(4'd1, 4'd0, 1'b0, 1'b0);
    wait_rsp("t4");
    check("t4_err", 32'(bus.rsp_err), 32'd1);
    check("t4_sum", 32'(bus.rsp_sum), 32'd0);
    drain("t4", 50);
    ill_mode = 1'b0;

    // Reset during DATA while the ALU still holds its result.
    data_delay = 1;
    null_delay = 12;
    send(4'd5, 4'd6, 1'b0, 1'b0);
    n = 0;
    while (!out_data && n < 10) begin
      step();
      n++;
    end
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_dr_a_null", 32'(bus.dr_a), 32'd0);
    check("t5_dr_b_null", 32'(bus.dr_b), 32'd0);
    check("t5_dr_opr_null", 32'(bus.dr_opr), 32'd0);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("t5_req_ready_busy", 32'(bus.req_ready), 32'd0);
    n = 0;
    while (!bus.req_ready && n < 40) begin
      step();
      n++;
    end
    check("t5_req_ready_after_null", 32'(bus.req_ready), 32'd1);
    check("t5_alu_was_null", 32'(out_data), 32'd0);
    null_delay = 1;
    repeat (2) step();
    check("t5_no_response", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back: 16 requests with req_valid held high.
    data_delay = 2;
    for (int i = 0; i < 16; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    bus.req_valid = 1'b0;
    drain("t6", 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
